// File: rtl/retire_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retire_unit_pkg
// Brief    : Shared sizing constants and types for the in-order retire stage.
// Revision : 1.0
// ============================================================================
package retire_unit_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int ROB_SZ        = 15;
  localparam int NUM_ARCH_REGS = 32;

  // Tag 0 is reserved as "invalid", so the tag space must cover ROB_SZ+1 codes.
  localparam int ROB_TAG_W_DEF = $clog2(ROB_SZ + 1);
  localparam int REG_IDX_W_DEF = $clog2(NUM_ARCH_REGS);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } RETIRE_STATE;

  typedef struct packed {
    logic                     we;
    logic [REG_IDX_W_DEF-1:0] waddr;
    logic [XLEN_DEF-1:0]      wdata;
  } RT_RF_PACKET;

endpackage
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ============================================================================
// Module   : retire_counter
// Brief    : 64-bit enable-gated counter with synchronous active-low clear.
// Revision : 1.0
// ============================================================================
module retire_counter (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        enable,
  output logic [63:0] count
);

  logic [63:0] r_count;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_count <= 64'd0;
    end else if (enable) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : retire_unit
// Brief    : In-order commit of the ROB head: regfile write, map clear,
//            mispredict squash/redirect with drain, halt/illegal termination.
// Revision : 1.0
// ============================================================================
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ROB_TAG_W = ROB_TAG_W_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 head_valid,
  input  logic                 head_complete,
  input  logic [ROB_TAG_W-1:0] head_tag,
  input  logic                 head_has_dest,
  input  logic [REG_IDX_W-1:0] head_dest_reg,
  input  logic [XLEN-1:0]      head_value,
  input  logic                 head_mispredict,
  input  logic [XLEN-1:0]      head_branch_target,
  input  logic                 head_halt,
  input  logic                 head_illegal,
  input  logic                 rob_empty,
  output logic                 retire_ack,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 map_clear_valid,
  output logic [ROB_TAG_W-1:0] map_clear_tag,
  output logic                 squash,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 draining,
  output logic                 halted,
  output logic                 halt_illegal,
  output logic [63:0]          retired_count
);

  RETIRE_STATE r_state;
  RETIRE_STATE w_state_next;

  logic w_retire_fire;
  logic w_terminate;
  logic w_mispredict_fire;
  logic w_rf_we_next;

  RT_RF_PACKET          r_rf;
  logic                 r_map_clear_valid;
  logic [ROB_TAG_W-1:0] r_map_clear_tag;
  logic                 r_squash;
  logic [XLEN-1:0]      r_redirect_pc;
  logic                 r_halted;
  logic                 r_halt_illegal;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; illegal and halt outrank a mispredict on the same entry
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_retire_fire) begin
          if (head_illegal || head_halt) begin
            w_state_next = HALTED;
          end else if (head_mispredict) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rob_empty) begin
          w_state_next = RUN;
        end
      end
      HALTED:  w_state_next = HALTED;
      default: w_state_next = RUN;
    endcase
  end

  // Output decode
  always_comb begin
    w_retire_fire     = (r_state == RUN) && head_valid && head_complete;
    w_terminate       = w_retire_fire && (head_illegal || head_halt);
    w_mispredict_fire = w_retire_fire && !head_illegal && !head_halt && head_mispredict;
    w_rf_we_next      = w_retire_fire && head_has_dest && (head_dest_reg != '0);
    retire_ack        = w_retire_fire;
    draining          = (r_state == DRAIN);
  end

  // Registered commit side effects; data fields hold when nothing fires
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rf              <= '0;
      r_map_clear_valid <= 1'b0;
      r_map_clear_tag   <= '0;
      r_squash          <= 1'b0;
      r_redirect_pc     <= '0;
      r_halted          <= 1'b0;
      r_halt_illegal    <= 1'b0;
    end else begin
      r_rf.we           <= w_rf_we_next;
      r_map_clear_valid <= w_retire_fire;
      r_squash          <= w_mispredict_fire;
      if (w_retire_fire) begin
        r_rf.waddr      <= head_dest_reg;
        r_rf.wdata      <= head_value;
        r_map_clear_tag <= head_tag;
      end
      if (w_mispredict_fire) begin
        r_redirect_pc <= head_branch_target;
      end
      if (w_terminate) begin
        r_halted       <= 1'b1;
        r_halt_illegal <= head_illegal;
      end
    end
  end

  retire_counter u_retire_counter (
    .clock   (clock),
    .clear_n (reset),
    .enable  (w_retire_fire),
    .count   (retired_count)
  );

  assign rf_we           = r_rf.we;
  assign rf_waddr        = r_rf.waddr;
  assign rf_wdata        = r_rf.wdata;
  assign map_clear_valid = r_map_clear_valid;
  assign map_clear_tag   = r_map_clear_tag;
  assign squash          = r_squash;
  assign redirect_valid  = r_squash;
  assign redirect_pc     = r_redirect_pc;
  assign halted          = r_halted;
  assign halt_illegal    = r_halt_illegal;

endmodule
`default_nettype wire

// File: tb/tb_retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_unit
// Brief    : Directed self-checking bench for retire_unit.
// Revision : 1.0
// ============================================================================
module tb_retire_unit;

  logic        clock;
  logic        reset;
  logic        head_valid;
  logic        head_complete;
  logic [3:0]  head_tag;
  logic        head_has_dest;
  logic [4:0]  head_dest_reg;
  logic [31:0] head_value;
  logic        head_mispredict;
  logic [31:0] head_branch_target;
  logic        head_halt;
  logic        head_illegal;
  logic        rob_empty;
  logic        retire_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        map_clear_valid;
  logic [3:0]  map_clear_tag;
  logic        squash;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        draining;
  logic        halted;
  logic        halt_illegal;
  logic [63:0] retired_count;

  int errors = 0;
  int checks = 0;

  retire_unit dut (
    .clock              (clock),
    .reset              (reset),
    .head_valid         (head_valid),
    .head_complete      (head_complete),
    .head_tag           (head_tag),
    .head_has_dest      (head_has_dest),
    .head_dest_reg      (head_dest_reg),
    .head_value         (head_value),
    .head_mispredict    (head_mispredict),
    .head_branch_target (head_branch_target),
    .head_halt          (head_halt),
    .head_illegal       (head_illegal),
    .rob_empty          (rob_empty),
    .retire_ack         (retire_ack),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .map_clear_valid    (map_clear_valid),
    .map_clear_tag      (map_clear_tag),
    .squash             (squash),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .draining           (draining),
    .halted             (halted),
    .halt_illegal       (halt_illegal),
    .retired_count      (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_head(input logic v, input logic [3:0] tag, input logic hd,
                          input logic [4:0] dst, input logic [31:0] val);
    head_valid    = v;
    head_complete = v;
    head_tag      = tag;
    head_has_dest = hd;
    head_dest_reg = dst;
    head_value    = val;
  endtask

  initial begin
    reset = 1'b0;
    set_head(1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    head_mispredict    = 1'b0;
    head_branch_target = 32'd0;
    head_halt          = 1'b0;
    head_illegal       = 1'b0;
    rob_empty          = 1'b0;
    step();
    step();
    reset = 1'b1;

    // Reset state
    chk("rst_rf_we", rf_we, 0);
    chk("rst_map_clear", map_clear_valid, 0);
    chk("rst_squash", squash, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_draining", draining, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_ack", retire_ack, 0);

    // Complete without valid never fires
    head_complete = 1'b1;
    #1 chk("complete_only_ack", retire_ack, 0);
    step();
    chk("complete_only_count", retired_count, 0);

    // Plain retirement
    set_head(1'b1, 4'd3, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1 chk("t1_ack", retire_ack, 1);
    step();
    chk("t1_rf_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("t1_mcv", map_clear_valid, 1);
    chk("t1_mtag", map_clear_tag, 3);
    chk("t1_count", retired_count, 1);

    // Write to x0: mapping cleared, no regfile write
    set_head(1'b1, 4'd4, 1'b1, 5'd0, 32'h1234);
    #1 chk("t2_ack", retire_ack, 1);
    step();
    chk("t2_rf_we", rf_we, 0);
    chk("t2_mcv", map_clear_valid, 1);
    chk("t2_mtag", map_clear_tag, 4);
    chk("t2_count", retired_count, 2);

    set_head(1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("idle_mcv", map_clear_valid, 0);
    chk("idle_rf_we", rf_we, 0);
    chk("idle_waddr_hold", rf_waddr, 0);
    chk("idle_count", retired_count, 2);

    // Mispredict with link write, then drain
    set_head(1'b1, 4'd5, 1'b1, 5'd1, 32'h44);
    head_mispredict    = 1'b1;
    head_branch_target = 32'h0000_0100;
    #1 chk("t3_ack", retire_ack, 1);
    step();
    head_mispredict = 1'b0;
    set_head(1'b1, 4'd6, 1'b1, 5'd2, 32'h66);
    #0;
    chk("t3_squash", squash, 1);
    chk("t3_redirect", redirect_valid, 1);
    chk("t3_pc", redirect_pc, 32'h100);
    chk("t3_rf_we", rf_we, 1);
    chk("t3_waddr", rf_waddr, 1);
    chk("t3_draining", draining, 1);
    chk("t3_count", retired_count, 3);
    chk("t3_drain_ack0", retire_ack, 0);
    step();
    chk("t3_squash_1cyc", squash, 0);
    chk("t3_redirect_1cyc", redirect_valid, 0);
    chk("t3_drain_ack1", retire_ack, 0);
    step();
    chk("t3_drain_ack2", retire_ack, 0);
    chk("t3_drain_count", retired_count, 3);
    rob_empty = 1'b1;
    #1 chk("t3_empty_ack", retire_ack, 0);
    step();
    rob_empty = 1'b0;
    #0;
    chk("t3_resume_draining", draining, 0);
    chk("t3_resume_ack", retire_ack, 1);
    step();
    chk("t3_resume_waddr", rf_waddr, 2);
    chk("t3_resume_wdata", rf_wdata, 32'h66);
    chk("t3_resume_count", retired_count, 4);

    // Back-to-back retirement
    for (int i = 0; i < 4; i++) begin
      set_head(1'b1, 4'(7 + i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      #0 chk("t4_ack", retire_ack, 1);
      step();
      chk("t4_wdata", rf_wdata, 32'h100 + 32'(i));
      chk("t4_count", retired_count, 64'(5 + i));
    end
    set_head(1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("t4_idle_count", retired_count, 8);

    // Reset during drain
    set_head(1'b1, 4'd1, 1'b0, 5'd0, 32'd0);
    head_mispredict    = 1'b1;
    head_branch_target = 32'h200;
    step();
    head_mispredict = 1'b0;
    set_head(1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_squash", squash, 1);
    chk("t6_count", retired_count, 9);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t6_squash_clr", squash, 0);
    chk("t6_count_clr", retired_count, 0);
    chk("t6_draining", draining, 0);
    chk("t6_halted", halted, 0);
    set_head(1'b1, 4'd2, 1'b1, 5'd7, 32'h77);
    #0 chk("t6_run_ack", retire_ack, 1);
    step();
    chk("t6_run_count", retired_count, 1);

    // Halt outranks mispredict
    set_head(1'b1, 4'd2, 1'b1, 5'd3, 32'h33);
    head_halt       = 1'b1;
    head_mispredict = 1'b1;
    #0 chk("t5_ack", retire_ack, 1);
    step();
    head_halt       = 1'b0;
    head_mispredict = 1'b0;
    set_head(1'b1, 4'd9, 1'b1, 5'd4, 32'h99);
    #0;
    chk("t5_halted", halted, 1);
    chk("t5_cause", halt_illegal, 0);
    chk("t5_squash", squash, 0);
    chk("t5_rf_we", rf_we, 1);
    chk("t5_count", retired_count, 2);
    chk("t5_noack", retire_ack, 0);
    step();
    chk("t5_frozen_we", rf_we, 0);
    chk("t5_frozen_mcv", map_clear_valid, 0);
    chk("t5_frozen_count", retired_count, 2);
    chk("t5_still_halted", halted, 1);

    // Illegal termination after reset
    reset = 1'b0;
    set_head(1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    step();
    reset = 1'b1;
    chk("t5_rst_halted", halted, 0);
    set_head(1'b1, 4'd8, 1'b0, 5'd0, 32'd0);
    head_illegal = 1'b1;
    step();
    head_illegal = 1'b0;
    set_head(1'b1, 4'd9, 1'b1, 5'd4, 32'h99);
    #0;
    chk("t5i_halted", halted, 1);
    chk("t5i_cause", halt_illegal, 1);
    chk("t5i_squash", squash, 0);
    chk("t5i_count", retired_count, 1);
    chk("t5i_noack", retire_ack, 0);
    step();
    chk("t5i_frozen_count", retired_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
